// File: rtl/uart_tx_engine.sv
// UART transmitter: one-byte holding register feeding an 8N1 shifter.
// Back-to-back bytes go out with no idle gap when the holder is refilled early.
module uart_tx_engine #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       TX_BUSY,
  output logic       UART_TX
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state;
  logic        hold_full;
  logic [7:0]  hold_q;
  logic [7:0]  shift_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic        tx_q;

  logic bit_end;
  logic accept;
  logic load;

  assign bit_end = (baud_q == BAUD_LAST);
  assign accept  = TX_EN & ~hold_full;
  // holder drains into the shifter from IDLE or on the edge closing STOP
  assign load    = hold_full &
                   ((state == IDLE) | ((state == STOP) & bit_end));

  assign TX_STATUS = ~hold_full;
  assign TX_BUSY   = (state != IDLE);
  assign UART_TX   = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_q    <= 8'h00;
      shift_q   <= 8'h00;
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      if (accept) begin
        hold_q    <= TX_DATA;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (load) begin
            shift_q <= hold_q;
            state   <= START;
            tx_q    <= 1'b0;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx_q   <= shift_q[0];
            baud_q <= 16'd0;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= 16'd0;
            if (bit_q == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= 16'd0;
            if (load) begin
              shift_q <= hold_q;
              state   <= START;
              tx_q    <= 1'b0;
              bit_q   <= 3'd0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port TX_DATA  input  8  byte to transmit, sampled only when a send is accepted.
REQ-005 SHALL have port TX_EN  input  1  one-cycle send request from the peripheral bus block.
REQ-006 SHALL have port TX_STATUS  output  1  1 = holding register empty, a send is accepted this cycle.
REQ-007 SHALL have port TX_BUSY  output  1  1 = a frame is on the line (state not IDLE).
REQ-008 SHALL have port UART_TX  output  1  serial line, idle high, driven from a flop.

Function
REQ-009 SHALL hold one byte in a holding register plus one byte in a shift register.
REQ-010 SHALL accept a send on any rising edge with TX_EN=1 and TX_STATUS=1: TX_DATA loaded into the holding register, holding-full set.
REQ-011 SHALL ignore TX_EN while TX_STATUS=0; the byte is dropped; no state changes.
REQ-012 SHALL drive TX_STATUS = NOT holding-full, combinationally from the flag.
REQ-013 SHALL use states IDLE, START, DATA, STOP.
REQ-014 SHALL, in IDLE with holding-full=1, on the next edge: copy holding to shifter, clear holding-full, go to START, drive UART_TX=0, clear bit counter.
REQ-015 SHALL give latency: edge N accepts; at edge N+1 UART_TX falls and TX_STATUS returns to 1.
REQ-016 SHALL hold every bit (start, 8 data, stop) for exactly CLKS_PER_BIT cycles, counted by a 16-bit baud counter that restarts at each bit boundary.
REQ-017 SHALL send data LSB first; DATA holds bit index 0..7; after bit 7 go to STOP driving UART_TX=1.
REQ-018 SHALL, at the end of STOP: if holding-full=1, load the next byte and enter START on that same edge (no idle gap, frame 10*CLKS_PER_BIT cycles); else enter IDLE with UART_TX=1.
REQ-019 SHALL accept a new byte into the holding register during any state, including the edge where STOP ends (the new byte is then taken at the following edge, adding one idle-high cycle).
REQ-020 SHALL drive TX_BUSY=1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 SHALL never glitch UART_TX; every change occurs only on a bit boundary edge.

Reset
REQ-022 SHALL, on reset=1 (asynchronous, any time including mid-frame): state IDLE, UART_TX=1, holding-full=0 (TX_STATUS=1), TX_BUSY=0, baud and bit counters 0, holding and shift registers 0x00.
REQ-023 SHALL abort an in-progress frame on reset with no resumption; the line returns high immediately.
REQ-024 SHALL accept a send on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4)
REQ-025 SHALL cover single byte: TX_EN pulse with 0xA5 at edge N -> UART_TX low at N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles, TX_BUSY low at N+41.
REQ-026 SHALL cover back-to-back: 0x55 at edge N, 0x0F at N+2 -> TX_STATUS=0 from N+2 until N+41, second start bit begins at N+41 with no idle cycle, total 80 line cycles.
REQ-027 SHALL cover overrun: a third TX_EN while TX_STATUS=0 -> byte dropped; only the two accepted bytes appear on UART_TX.
REQ-028 SHALL cover reset mid-frame: reset asserted during data bit 3 -> UART_TX=1, TX_BUSY=0 and TX_STATUS=1 asynchronously; a new 0x81 after release transmits correctly.
REQ-029 SHALL cover the boundary: byte accepted on the edge ending STOP -> exactly one idle-high cycle, then start bit.
REQ-030 SHALL cover a self-check where a bench receiver samples mid-bit and reconstructs 256 random bytes with zero mismatches.
